// File: rtl/usb_rx_rcu.sv
// USB full-speed receiver control unit: sync check, data-byte store strobes, EOP validation, error recovery.
// Optional PID check is enabled by defining USB_RCU_PID_CHECK_EN, which also adds the `pid` output.
module usb_rx_rcu #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       pkt_done
`ifdef USB_RCU_PID_CHECK_EN
  ,
  output logic [3:0] pid
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    RCV,
    STORE,
    EOP1,
    EOP2,
    DONE,
    ERR_WAIT,
    ERR_EOP1,
    ERR_IDLE
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic       eop_s;

  // SE0 only counts when seen on a bit-sample strobe.
  assign eop_s = eop & shift_enable;

`ifdef USB_RCU_PID_CHECK_EN
  logic pid_ok;
  assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);
`endif

  // Outputs are registered alongside the state so each one equals a decode of
  // the state being entered; no input ever reaches an output combinationally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: asynchronous reset puts the FSM in IDLE immediately, dropping any
      // pending STORE strobe without waiting for a clock.
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
      pkt_done <= 1'b0;
`ifdef USB_RCU_PID_CHECK_EN
      pid      <= 4'd0;
`endif
    end else begin
      w_enable <= 1'b0;
      pkt_done <= 1'b0;

      if ((state == SYNC_WAIT || state == RCV) && shift_enable)
        bit_cnt <= bit_cnt + 3'd1;

      unique case (state)
        IDLE, ERR_IDLE: begin
          if (d_edge) begin
            state    <= SYNC_WAIT;
            rcving   <= 1'b1;
            r_error  <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
`ifdef USB_RCU_PID_CHECK_EN
            pid      <= 4'd0;
`endif
          end
        end

        SYNC_WAIT: begin
          if (eop_s) begin
            state   <= ERR_EOP1;
            r_error <= 1'b1;
          end else if (byte_received) begin
            if (rcv_data == SYNC_BYTE) begin
              state <= RCV;
            end else begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end
          end
        end

        RCV: begin
          if (eop_s) begin
            if (bit_cnt == 3'd0) begin
              state <= EOP1;
            end else begin
              // SE0 mid-byte: the packet ended on a partial byte.
              state   <= ERR_EOP1;
              r_error <= 1'b1;
            end
          end else if (byte_received) begin
            if (byte_cnt >= MAX_CNT) begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
`ifdef USB_RCU_PID_CHECK_EN
            end else if (byte_cnt == 8'd0 && !pid_ok) begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end else begin
              if (byte_cnt == 8'd0)
                pid <= rcv_data[3:0];
              state    <= STORE;
              w_enable <= 1'b1;
            end
`else
            end else begin
              state    <= STORE;
              w_enable <= 1'b1;
            end
`endif
          end
        end

        STORE: begin
          state    <= RCV;
          byte_cnt <= byte_cnt + 8'd1;
        end

        EOP1: begin
          if (eop_s) begin
            state <= EOP2;
          end else if (shift_enable) begin
            // Single-bit SE0 is not a valid end of packet.
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end
        end

        EOP2: begin
          if (d_edge) begin
            state    <= DONE;
            rcving   <= 1'b0;
            pkt_done <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        ERR_WAIT: begin
          if (eop_s)
            state <= ERR_EOP1;
        end

        ERR_EOP1: begin
          if (d_edge) begin
            state  <= ERR_IDLE;
            rcving <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rcving  <= 1'b0;
          r_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
